ecc_point_double_ctrl: RTL and testbench
========================================

// Module: ecc_point_double_ctrl
// PURPOSE
//  Control stage directly upstream of the GFAU: sequences one affine point doubling
//  (x3,y3) = 2(x,y) on y^2 = x^3 + a*x + b over GF(prime) as 12 GFAU ops.
//  Drives operation_select/in_0/in_1/done_from_control; consumes result/done_to_control.
//  Holds an 8x32 scratch register file; reports the result with a one-cycle done pulse.
// PARAMETERS
//  SIZE     32    operand / register width (must match GFAU)
//  TIMEOUT  1023  max cycles waited for gf_done per op before error abort
// PORTS
//  i_clk     in   1     clock; all logic on rising edge
//  i_rst     in   1     synchronous, active-high reset
//  start     in   1     begin doubling; sampled only in IDLE
//  x_in      in   SIZE  input point x
//  y_in      in   SIZE  input point y
//  a_coef    in   SIZE  curve coefficient a
//  in_inf    in   1     input is point at infinity
//  busy      out  1     high from accepted start until done
//  done      out  1     one-cycle pulse: x_out/y_out/out_inf/err valid
//  x_out     out  SIZE  result x (held until next done)
//  y_out     out  SIZE  result y (held until next done)
//  out_inf   out  1     result is point at infinity
//  err       out  1     op timed out; result invalid (held until next done)
//  gf_op     out  2     -> GFAU operation_select (0 add,1 sub,2 mult,3 div)
//  gf_in_0   out  SIZE  -> GFAU in_0
//  gf_in_1   out  SIZE  -> GFAU in_1
//  gf_start  out  1     -> GFAU done_from_control (one-cycle pulse)
//  gf_result in   SIZE  <- GFAU result
//  gf_done   in   1     <- GFAU done_to_control
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pc 0; timeout counter 0; regfile 0.
//  Reset mid-operation aborts immediately; no done pulse; gf_start low next cycle.
//  Regs: R0=x R1=y R2=a R3..R7 temps. Op d = s0 OP s1; div computes in_0/in_1.
//  Microcode (pc: op d,s0,s1): 0 mul R3,R0,R0 | 1 add R4,R3,R3 | 2 add R4,R4,R3
//   3 add R4,R4,R2 | 4 add R5,R1,R1 | 5 div R6,R4,R5 | 6 mul R3,R6,R6
//   7 add R7,R0,R0 | 8 sub R3,R3,R7 | 9 sub R7,R0,R3 | 10 mul R7,R6,R7
//   11 sub R7,R7,R1. Result x_out=R3, y_out=R7.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | FINISH) -> IDLE.
//   IDLE: on start, load R0/R1/R2, pc=0, busy=1; if in_inf or y_in==0 go FINISH
//         with out_inf=1 (no GFAU op issued), else ISSUE. start ignored when busy.
//   ISSUE: gf_start=1 exactly one cycle; clear timeout counter; go WAIT.
//   WAIT: on gf_done write gf_result to R[d]; pc==11 -> FINISH, else pc++ -> ISSUE.
//         gf_done in same cycle as timeout expiry: gf_done wins.
//         Counter reaches TIMEOUT without gf_done: err=1 -> FINISH.
//   FINISH: register x_out/y_out/out_inf/err, done=1, busy=0 -> IDLE.
//  gf_op/gf_in_0/gf_in_1 = ucode[pc] decode + regfile reads; stable through ISSUE
//   and all of WAIT (regfile unwritten until gf_done); 0 in IDLE/FINISH.
//  gf_done outside WAIT is ignored. Only first gf_done after each gf_start is used.
//  Latency (normal): 1 + sum over ops of (1 + GFAU latency) + 1 cycles start->done.
//  Latency (infinity/y==0): done 2 cycles after start.
//  No arithmetic in this block; all field math is GFAU's (operand domain is caller's).
// STRUCTURE
//  Shared package ecc_pkg: GF_ADD/GF_SUB/GF_MULT/GF_DIV codes, ucode word
//   {op[1:0], d[2:0], s0[2:0], s1[2:0]}, UCODE_LAST=11, register index constants.
//  Sub-module ecc_ucode_rom: combinational pc[3:0] -> ucode word.
// TESTING (bench uses GFAU interface model: plain mod-p math, programmable latency)
//  p=97,a=2,P=(3,6), latency 3 -> done, x_out=80, y_out=10, out_inf=0, err=0.
//  Same run: exactly 12 gf_start pulses, gf_op seq 2,0,0,0,0,3,2,0,1,1,2,1.
//  y_in=0 (and separately in_inf=1) -> out_inf=1, done 2 cycles after start, no gf_start.
//  start pulsed while busy -> ignored; single done; results equal case 1.
//  Model never asserts gf_done -> err=1, done TIMEOUT+2 cycles after first gf_start.
//  i_rst during WAIT of pc 5 -> all outputs 0 next cycle; new start yields case 1 result.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared definitions for the point-doubling controller: GFAU op codes,
// microcode word layout and scratch register indices.
package ecc_pkg;

  typedef enum logic [1:0] {
    GF_ADD  = 2'd0,
    GF_SUB  = 2'd1,
    GF_MULT = 2'd2,
    GF_DIV  = 2'd3
  } gf_op_t;

  typedef struct packed {
    gf_op_t     op;
    logic [2:0] d;
    logic [2:0] s0;
    logic [2:0] s1;
  } ucode_t;

  localparam logic [3:0] UCODE_LAST = 4'd11;

  localparam logic [2:0] R_X  = 3'd0;
  localparam logic [2:0] R_Y  = 3'd1;
  localparam logic [2:0] R_A  = 3'd2;
  localparam logic [2:0] R_T3 = 3'd3;
  localparam logic [2:0] R_T4 = 3'd4;
  localparam logic [2:0] R_T5 = 3'd5;
  localparam logic [2:0] R_T6 = 3'd6;
  localparam logic [2:0] R_T7 = 3'd7;

  function automatic ucode_t make_uc(gf_op_t op, logic [2:0] d, logic [2:0] s0, logic [2:0] s1);
    ucode_t w;
    w.op = op;
    w.d  = d;
    w.s0 = s0;
    w.s1 = s1;
    return w;
  endfunction

endpackage

// File: rtl/ecc_ucode_rom.sv
// Microcode for affine doubling: lambda = (3x^2+a)/(2y), x3 = lambda^2-2x,
// y3 = lambda*(x-x3)-y. Pure combinational lookup.
module ecc_ucode_rom
  import ecc_pkg::*;
(
  input  logic [3:0] pc,
  output ucode_t     word
);

  // pc -> op d,s0,s1
  always_comb begin
    case (pc)
      4'd0:    word = make_uc(GF_MULT, R_T3, R_X,  R_X);
      4'd1:    word = make_uc(GF_ADD,  R_T4, R_T3, R_T3);
      4'd2:    word = make_uc(GF_ADD,  R_T4, R_T4, R_T3);
      4'd3:    word = make_uc(GF_ADD,  R_T4, R_T4, R_A);
      4'd4:    word = make_uc(GF_ADD,  R_T5, R_Y,  R_Y);
      4'd5:    word = make_uc(GF_DIV,  R_T6, R_T4, R_T5);
      4'd6:    word = make_uc(GF_MULT, R_T3, R_T6, R_T6);
      4'd7:    word = make_uc(GF_ADD,  R_T7, R_X,  R_X);
      4'd8:    word = make_uc(GF_SUB,  R_T3, R_T3, R_T7);
      4'd9:    word = make_uc(GF_SUB,  R_T7, R_X,  R_T3);
      4'd10:   word = make_uc(GF_MULT, R_T7, R_T6, R_T7);
      4'd11:   word = make_uc(GF_SUB,  R_T7, R_T7, R_Y);
      default: word = make_uc(GF_ADD,  R_T3, R_X,  R_X);
    endcase
  end

endmodule

// File: rtl/ecc_point_double_ctrl.sv
// Sequences one affine point doubling as 12 GFAU operations over an 8-entry
// scratch register file; all field arithmetic happens in the GFAU.
module ecc_point_double_ctrl
  import ecc_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic [SIZE-1:0] x_in,
  input  logic [SIZE-1:0] y_in,
  input  logic [SIZE-1:0] a_coef,
  input  logic            in_inf,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] x_out,
  output logic [SIZE-1:0] y_out,
  output logic            out_inf,
  output logic            err,
  output logic [1:0]      gf_op,
  output logic [SIZE-1:0] gf_in_0,
  output logic [SIZE-1:0] gf_in_1,
  output logic            gf_start,
  input  logic [SIZE-1:0] gf_result,
  input  logic            gf_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t          state_r, state_s;
  logic [3:0]      pc_r, pc_s;
  logic [CNT_W-1:0] cnt_r;
  logic [SIZE-1:0] rf_r [8];
  logic [SIZE-1:0] rf_s [8];
  logic [2:0]      dst_r;
  logic            inf_r, inf_s, err_r, err_s;
  ucode_t          word_s;

  // Addressed by the next pc so operands can be registered on entry to ISSUE.
  ecc_ucode_rom u_rom (
    .pc   (pc_s),
    .word (word_s)
  );

  // Next-state, pc and register-file write (the write is forwarded to the operand regs)
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    rf_s    = rf_r;
    inf_s   = inf_r;
    err_s   = err_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          rf_s[R_X] = x_in;
          rf_s[R_Y] = y_in;
          rf_s[R_A] = a_coef;
          pc_s      = 4'd0;
          err_s     = 1'b0;
          inf_s     = in_inf || (y_in == {SIZE{1'b0}});
          state_s   = (in_inf || (y_in == {SIZE{1'b0}})) ? S_FINISH : S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: state_s = S_WAIT;
      S_WAIT: begin
        if (gf_done) begin
          rf_s[dst_r] = gf_result;
          if (pc_r == UCODE_LAST) begin
            state_s = S_FINISH;
          end else begin
            pc_s    = pc_r + 4'd1;
            state_s = S_ISSUE;
          end
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          err_s   = 1'b1;
          state_s = S_FINISH;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // State, register file and all registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= S_IDLE;
      pc_r     <= 4'd0;
      cnt_r    <= {CNT_W{1'b0}};
      dst_r    <= 3'd0;
      inf_r    <= 1'b0;
      err_r    <= 1'b0;
      for (int i = 0; i < 8; i++) rf_r[i] <= {SIZE{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      x_out    <= {SIZE{1'b0}};
      y_out    <= {SIZE{1'b0}};
      out_inf  <= 1'b0;
      err      <= 1'b0;
      gf_op    <= 2'd0;
      gf_in_0  <= {SIZE{1'b0}};
      gf_in_1  <= {SIZE{1'b0}};
      gf_start <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      rf_r     <= rf_s;
      inf_r    <= inf_s;
      err_r    <= err_s;
      dst_r    <= word_s.d;
      cnt_r    <= (state_r == S_WAIT) ? cnt_r + CNT_W'(1) : {CNT_W{1'b0}};
      busy     <= (state_s == S_ISSUE) || (state_s == S_WAIT) || (state_s == S_FINISH);
      done     <= (state_r == S_FINISH);
      gf_start <= (state_s == S_ISSUE);
      if (state_r == S_FINISH) begin
        x_out   <= rf_r[R_T3];
        y_out   <= rf_r[R_T7];
        out_inf <= inf_r;
        err     <= err_r;
      end else begin
        x_out   <= x_out;
        y_out   <= y_out;
        out_inf <= out_inf;
        err     <= err;
      end
      // Operands only change when a new op is issued; the regfile is frozen during WAIT.
      if ((state_s == S_ISSUE) || (state_s == S_WAIT)) begin
        gf_op   <= word_s.op;
        gf_in_0 <= rf_s[word_s.s0];
        gf_in_1 <= rf_s[word_s.s1];
      end else begin
        gf_op   <= 2'd0;
        gf_in_0 <= {SIZE{1'b0}};
        gf_in_1 <= {SIZE{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_ecc_point_double_ctrl.sv
// Directed bench for ecc_point_double_ctrl with a mod-97 GFAU model of programmable latency.
module tb_ecc_point_double_ctrl;

  localparam int SIZE    = 32;
  localparam int TIMEOUT = 1023;
  localparam int P       = 97;

  logic            clk, rst, start, in_inf;
  logic [SIZE-1:0] x_in, y_in, a_coef;
  logic            busy, done, out_inf, err;
  logic [SIZE-1:0] x_out, y_out;
  logic [1:0]      gf_op;
  logic [SIZE-1:0] gf_in_0, gf_in_1, gf_result;
  logic            gf_start, gf_done;

  int n_checks = 0;
  int n_pass   = 0;

  int        lat      = 3;
  bit        model_en = 1'b1;
  int        total_starts;
  logic [1:0] ops [256];

  typedef struct {
    logic [31:0] x, y, a;
    logic        inf;
    logic [31:0] ex, ey;
    logic        einf;
    int          glat;
    int          elat;
    int          nops;
  } vec_t;

  vec_t vecs [6];

  ecc_point_double_ctrl #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .a_coef   (a_coef),
    .in_inf   (in_inf),
    .busy     (busy),
    .done     (done),
    .x_out    (x_out),
    .y_out    (y_out),
    .out_inf  (out_inf),
    .err      (err),
    .gf_op    (gf_op),
    .gf_in_0  (gf_in_0),
    .gf_in_1  (gf_in_1),
    .gf_start (gf_start),
    .gf_result(gf_result),
    .gf_done  (gf_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] gf_calc(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint unsigned aa, bb, inv;
    aa  = longint'(a) % P;
    bb  = longint'(b) % P;
    inv = 0;
    case (op)
      2'd0:    return 32'((aa + bb) % P);
      2'd1:    return 32'((aa + P - bb) % P);
      2'd2:    return 32'((aa * bb) % P);
      default: begin
        for (int k = 1; k < P; k++) if ((bb * longint'(k)) % P == 1) inv = longint'(k);
        return 32'((aa * inv) % P);
      end
    endcase
  endfunction

  // GFAU model: result appears gf_done 'lat' cycles after gf_start is sampled.
  initial begin
    int m_cnt;
    bit m_busy;
    logic [31:0] m_res;
    gf_done = 1'b0; gf_result = '0; total_starts = 0; m_cnt = 0; m_busy = 1'b0; m_res = '0;
    forever begin
      @(negedge clk);
      gf_done = 1'b0;
      if (rst) begin
        m_busy = 1'b0;
      end else begin
        if (m_busy) begin
          m_cnt--;
          if (m_cnt <= 0) begin
            gf_done   = 1'b1;
            gf_result = m_res;
            m_busy    = 1'b0;
          end
        end
        if (gf_start) begin
          ops[total_starts[7:0]] = gf_op;
          total_starts++;
          if (model_en) begin
            m_busy = 1'b1;
            m_cnt  = lat;
            m_res  = gf_calc(gf_op, gf_in_0, gf_in_1);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " ctrl_bits"}, {26'd0, busy, done, out_inf, err, gf_start, |gf_op}, 32'd0);
    check({tag, " x_out"}, x_out, 32'd0);
    check({tag, " y_out"}, y_out, 32'd0);
    check({tag, " gf_in"}, gf_in_0 | gf_in_1, 32'd0);
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    int base, cyc;
    bit seen;
    logic [23:0] seq;
    @(negedge clk);
    lat = v.glat;
    base = total_starts; seen = 1'b0; cyc = 0;
    x_in = v.x; y_in = v.y; a_coef = v.a; in_inf = v.inf; start = 1'b1;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
      end
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, cyc, v.elat);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " out_inf"}, {31'd0, out_inf}, {31'd0, v.einf});
    check({tag, " err"}, {31'd0, err}, 32'd0);
    if (!v.einf) begin
      check({tag, " x_out"}, x_out, v.ex);
      check({tag, " y_out"}, y_out, v.ey);
    end
    check({tag, " gf_start_count"}, total_starts - base, v.nops);
    if (v.nops == 12) begin
      seq = '0;
      for (int i = 0; i < 12; i++) seq = {seq[21:0], ops[(base + i) % 256]};
      check({tag, " gf_op_seq"}, {8'd0, seq}, 32'h0080_3859);
    end
    @(negedge clk);
    check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int base, cyc, ndone;
    bit seen;
    logic [31:0] xo, yo;

    vecs[0] = '{32'd3,  32'd6,  32'd2, 1'b0, 32'd80, 32'd10, 1'b0, 3, 50, 12};
    vecs[1] = '{32'd80, 32'd10, 32'd2, 1'b0, 32'd3,  32'd91, 1'b0, 3, 50, 12};
    vecs[2] = '{32'd0,  32'd1,  32'd0, 1'b0, 32'd0,  32'd96, 1'b0, 1, 26, 12};
    vecs[3] = '{32'd1,  32'd1,  32'd1, 1'b0, 32'd2,  32'd94, 1'b0, 5, 74, 12};
    vecs[4] = '{32'd3,  32'd6,  32'd2, 1'b1, 32'd0,  32'd0,  1'b1, 3, 2,  0};
    vecs[5] = '{32'd5,  32'd0,  32'd2, 1'b0, 32'd0,  32'd0,  1'b1, 3, 2,  0};

    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0; a_coef = '0; in_inf = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_and_check(vecs[i], $sformatf("vec%0d", i));

    // start re-pulsed mid-run with different operands must be ignored
    @(negedge clk);
    lat = 3; base = total_starts; ndone = 0; cyc = 0; xo = '0; yo = '0;
    x_in = 32'd3; y_in = 32'd6; a_coef = 32'd2; in_inf = 1'b0; start = 1'b1;
    while (cyc < 120) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 10);
      if (cyc == 10) begin x_in = 32'd1; y_in = 32'd1; a_coef = 32'd1; end
      if (done) begin ndone++; xo = x_out; yo = y_out; end
    end
    check("busy_start done_count", ndone, 32'd1);
    check("busy_start x_out", xo, 32'd80);
    check("busy_start y_out", yo, 32'd10);
    check("busy_start gf_start_count", total_starts - base, 32'd12);

    // reset while waiting on op 5 (the divide)
    @(negedge clk);
    base = total_starts; cyc = 0;
    x_in = 32'd3; y_in = 32'd6; a_coef = 32'd2; start = 1'b1;
    while ((total_starts - base) < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check("rst_mid reached_op5", total_starts - base, 32'd6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("rst_mid");
    rst = 1'b0;
    run_and_check(vecs[0], "after_rst");

    // GFAU never answers: timeout abort
    model_en = 1'b0;
    @(negedge clk);
    base = total_starts; cyc = 0; seen = 1'b0;
    x_in = 32'd3; y_in = 32'd6; a_coef = 32'd2; start = 1'b1;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (gf_start) seen = 1'b1;
    end
    check("timeout first_gf_start", {31'd0, seen}, 32'd1);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    check("timeout done_seen", {31'd0, seen}, 32'd1);
    check("timeout latency", cyc, TIMEOUT + 2);
    check("timeout err", {31'd0, err}, 32'd1);
    check("timeout out_inf", {31'd0, out_inf}, 32'd0);
    check("timeout gf_start_count", total_starts - base, 32'd1);
    model_en = 1'b1;
    run_and_check(vecs[0], "after_timeout");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
